// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-flip-flop counter sequencer.
//   state_t    : sequencer FSM states (IDLE / RUN / PAUSE)
//   jk_mode_t  : 2-bit {J,K} pair applied to one flip-flop
//   HOLD/CLR/SET/TOG : the four JK actions
//   force_mode : picks SET or CLR so a bit lands on a chosen value
package jk_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t HOLD = 2'b00;
  localparam jk_mode_t CLR  = 2'b01;
  localparam jk_mode_t SET  = 2'b10;
  localparam jk_mode_t TOG  = 2'b11;

  // Drive a bit to an absolute value regardless of its current Q.
  function automatic jk_mode_t force_mode(input logic v);
    return v ? SET : CLR;
  endfunction

endpackage

// File: rtl/jk_flipflop.sv
// Single JK flip-flop, one bit of the LED counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, Q -> 0
//   j, k  : 00 hold, 01 clear, 10 set, 11 toggle
//   q     : stored bit
module jk_flipflop (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_sequencer.sv
// Sequencer for a WIDTH-bit counter made of JK flip-flops driving LEDs.
// Holds the IDLE/RUN/PAUSE state, runs a PRESCALE-cycle tick prescaler and
// generates per-bit J/K controls for counting up/down, wrapping at
// 0/MAX_COUNT and loading a (saturated) preset.
//   input_clock1_1   : system clock, rising edge
//   input_reset_n1_2 : asynchronous active-low reset
//   input_start_3    : start / resume request
//   input_stop_4     : pause (from RUN) / clear to IDLE (from PAUSE)
//   input_dir_5      : 1 = up, 0 = down, sampled on tick edges
//   input_load_6     : load input_preset_7 on the next edge
//   input_preset_7   : load value, saturated to MAX_COUNT
//   output_count_8   : flip-flop Q vector
//   output_j_9       : J applied this cycle (combinational)
//   output_k_10      : K applied this cycle (combinational)
//   output_tc_11     : one-cycle pulse after a wrap edge
//   output_busy_12   : high while in RUN
module jk_counter_sequencer
  import jk_counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int PRESCALE  = 4,
  parameter int MAX_COUNT = 7
) (
  input  logic             input_clock1_1,
  input  logic             input_reset_n1_2,
  input  logic             input_start_3,
  input  logic             input_stop_4,
  input  logic             input_dir_5,
  input  logic             input_load_6,
  input  logic [WIDTH-1:0] input_preset_7,
  output logic [WIDTH-1:0] output_count_8,
  output logic [WIDTH-1:0] output_j_9,
  output logic [WIDTH-1:0] output_k_10,
  output logic             output_tc_11,
  output logic             output_busy_12
);

  localparam int               PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic             tc;
  logic             tick;
  logic             wrap;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] preset_sat;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] j_raw;
  logic [WIDTH-1:0] k_raw;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  assign tick       = (state == RUN) && (presc == PRE_LAST);
  assign at_max     = (count == MAX_V);
  assign at_zero    = (count == '0);
  assign preset_sat = (input_preset_7 > MAX_V) ? MAX_V : input_preset_7;

  // State / prescaler / tc registers
  always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
    if (!input_reset_n1_2) begin
      state <= IDLE;
      presc <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      tc    <= wrap;
    end
  end

  // Next state and prescaler. A load blocks start but not stop, and always
  // restarts the prescaler. A tick edge always wraps the prescaler to 0,
  // even when a coincident stop pauses the sequencer.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (input_start_3 && !input_load_6) state_nxt = RUN;
      end
      RUN: begin
        if (tick)               presc_nxt = '0;
        else if (!input_stop_4) presc_nxt = presc + PW'(1);
        if (input_stop_4) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (input_stop_4) begin
          state_nxt = IDLE;
          presc_nxt = '0;
        end else if (input_start_3 && !input_load_6) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        presc_nxt = '0;
      end
    endcase
    if (input_load_6) presc_nxt = '0;
  end

  // J/K generation. `chain` walks up from bit 0: for counting up it stays
  // set while all lower bits are 1, for counting down while they are all 0;
  // a bit toggles exactly when its chain is still set.
  always_comb begin
    logic     chain;
    jk_mode_t m;
    j_raw = '0;
    k_raw = '0;
    chain = 1'b1;
    m     = HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      m = HOLD;
      if (input_load_6) begin
        m = force_mode(preset_sat[i]);
      end else if (tick) begin
        if (input_dir_5) begin
          m     = at_max ? CLR : (chain ? TOG : HOLD);
          chain = chain & count[i];
        end else begin
          m     = at_zero ? force_mode(MAX_V[i]) : (chain ? TOG : HOLD);
          chain = chain & ~count[i];
        end
      end
      j_raw[i] = m[1];
      k_raw[i] = m[0];
    end
  end

  assign wrap = tick && !input_load_6 && (input_dir_5 ? at_max : at_zero);

  // Controls are forced to hold while reset is asserted so nothing
  // downstream sees a spurious set/clear request.
  assign j_vec = input_reset_n1_2 ? j_raw : '0;
  assign k_vec = input_reset_n1_2 ? k_raw : '0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_flipflop u_ff (
      .clk   (input_clock1_1),
      .rst_n (input_reset_n1_2),
      .j     (j_vec[g]),
      .k     (k_vec[g]),
      .q     (count[g])
    );
  end

  assign output_count_8 = count;
  assign output_j_9     = j_vec;
  assign output_k_10    = k_vec;
  assign output_tc_11   = tc;
  assign output_busy_12 = (state == RUN);

endmodule
